// File: rtl/lsu_ic_pkg.sv
// lsu_ic_pkg: shared types and constants for the LSU interconnect.
//   addr_region_t : byte base/length pair describing one address window
//   state_t       : transaction FSM states (ST_DRAIN exists only when
//                   LSU_AXI_TIMEOUT_EN is defined)
//   AXI_RESP_*    : AXI-Lite response codes
//   DEAD_BEEF     : load data returned for errored accesses
package lsu_ic_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] length;
  } addr_region_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_AW,
    ST_WR_B,
    ST_RESP
`ifdef LSU_AXI_TIMEOUT_EN
    , ST_DRAIN
`endif
  } state_t;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
  localparam logic [31:0] DEAD_BEEF       = 32'hDEAD_BEEF;

  // base <= addr < base+length, written as an offset compare so that a
  // window touching the top of the address space cannot wrap.
  function automatic logic region_hit(addr_region_t r, logic [31:0] addr);
    logic [31:0] off;
    off = addr - r.base;
    return (addr >= r.base) && (off < r.length);
  endfunction

endpackage

// File: rtl/lsu_interconnect_axil_decode.sv
// lsu_addr_decode: combinational address decode for the LSU interconnect.
//   addr       in  : CPU byte address
//   dmem_hit   out : address falls in the DMEM window
//   periph_hit out : address falls in the AXI-Lite peripheral window
//   dmem_word  out : DMEM word address (offset bits [ADDR_DMEM_WIDTH+1:2])
module lsu_addr_decode
  import lsu_ic_pkg::*;
#(
  parameter int           ADDR_DMEM_WIDTH = 10,
  parameter addr_region_t DMEM_REGION     = '0,
  parameter addr_region_t PERIPH_REGION   = '0
) (
  input  logic [31:0]                addr,
  output logic                       dmem_hit,
  output logic                       periph_hit,
  output logic [ADDR_DMEM_WIDTH-1:0] dmem_word
);

  logic [31:0] dmem_off;

  assign dmem_off   = addr - DMEM_REGION.base;
  assign dmem_hit   = (addr >= DMEM_REGION.base) && (dmem_off < DMEM_REGION.length);
  assign dmem_word  = dmem_off[ADDR_DMEM_WIDTH+1:2];
  assign periph_hit = region_hit(PERIPH_REGION, addr);

endmodule

// File: rtl/lsu_interconnect_axil.sv
// lsu_interconnect_axil: routes CPU load/store requests to zero-wait DMEM,
// an AXI4-Lite master (peripheral window) or an error responder.
//   clk/rst                      : clock, synchronous active-high reset
//   *_dmem                       : DMEM port (dout_dmem is combinational)
//   rready_lsu/rvalid_lsu        : load request / load complete
//   wvalid_lsu/wready_lsu        : store request / store complete
//   err_lsu                      : error flag qualifying the completion
//   addr_lsu/data_lsu_i/strb_lsu : request address, store data, strobes
//   data_lsu_o                   : load data
//   m_*                          : AXI4-Lite master channels
// Handshake: the CPU holds its request (and addr/data/strb) stable until
// the matching completion pulse; a store wins when both are requested and
// the load is served on a later cycle. AXI channels transfer on
// valid && ready at the rising edge; a valid, once raised, stays high
// until its own handshake.
// Optional feature macro: LSU_AXI_TIMEOUT_EN (AXI wait timeout + DRAIN).
module lsu_interconnect_axil
  import lsu_ic_pkg::*;
#(
  parameter int          ADDR_DMEM_WIDTH = 10,
  parameter logic [31:0] DMEM_BASE       = 32'h1000_0000,
  parameter logic [31:0] DMEM_LENGTH     = 32'(1) << (ADDR_DMEM_WIDTH + 2),
  parameter logic [31:0] PERIPH_BASE     = 32'h2000_0000,
  parameter logic [31:0] PERIPH_LENGTH   = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       we_dmem,
  output logic [3:0]                 wstrb_dmem,
  output logic [ADDR_DMEM_WIDTH-1:0] addr_dmem,
  output logic [31:0]                din_dmem,
  input  logic [31:0]                dout_dmem,
  input  logic                       rready_lsu,
  output logic                       rvalid_lsu,
  input  logic                       wvalid_lsu,
  output logic                       wready_lsu,
  output logic                       err_lsu,
  input  logic [3:0]                 strb_lsu,
  input  logic [31:0]                addr_lsu,
  input  logic [31:0]                data_lsu_i,
  output logic [31:0]                data_lsu_o,
  output logic [31:0]                m_awaddr,
  output logic [2:0]                 m_awprot,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [31:0]                m_wdata,
  output logic [3:0]                 m_wstrb,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [1:0]                 m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  output logic [31:0]                m_araddr,
  output logic [2:0]                 m_arprot,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  input  logic [31:0]                m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rvalid,
  output logic                       m_rready
);

  localparam addr_region_t DMEM_REGION   = '{base: DMEM_BASE, length: DMEM_LENGTH};
  localparam addr_region_t PERIPH_REGION = '{base: PERIPH_BASE, length: PERIPH_LENGTH};
  localparam logic [32:0]  DMEM_END      = {1'b0, DMEM_BASE} + {1'b0, DMEM_LENGTH};
  localparam logic [32:0]  PERIPH_END    = {1'b0, PERIPH_BASE} + {1'b0, PERIPH_LENGTH};

  if (DMEM_END > 33'h1_0000_0000) begin : g_dmem_wrap
    $error("DMEM window wraps past the top of the address space");
  end
  if (PERIPH_END > 33'h1_0000_0000) begin : g_periph_wrap
    $error("peripheral window wraps past the top of the address space");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic                       dmem_hit, periph_hit;
  logic [ADDR_DMEM_WIDTH-1:0] dmem_word;

  lsu_addr_decode #(
    .ADDR_DMEM_WIDTH(ADDR_DMEM_WIDTH),
    .DMEM_REGION    (DMEM_REGION),
    .PERIPH_REGION  (PERIPH_REGION)
  ) u_decode (
    .addr      (addr_lsu),
    .dmem_hit  (dmem_hit),
    .periph_hit(periph_hit),
    .dmem_word (dmem_word)
  );

  state_t      state, state_nxt;
  logic        aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic        is_wr, is_wr_nxt, err_q, err_nxt;
  logic [31:0] rdata_q, rdata_nxt;

  // Address/data/prot channels carry the held CPU request; only valids vary.
  assign m_awaddr = addr_lsu;
  assign m_araddr = addr_lsu;
  assign m_wdata  = data_lsu_i;
  assign m_wstrb  = strb_lsu;
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

`ifdef LSU_AXI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          waiting;
  // Channel work still owed to the slave after a timeout.
  logic ar_pend, r_pend, aw_pend, w_pend, b_pend;
  logic ar_pend_nxt, r_pend_nxt, aw_pend_nxt, w_pend_nxt, b_pend_nxt;

  assign waiting = (state == ST_RD_A) || (state == ST_RD_D) ||
                   (state == ST_WR_AW) || (state == ST_WR_B);

  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) cnt <= '0;
    else if (waiting)            cnt <= cnt + CW'(1);
    if (rst) begin
      ar_pend <= 1'b0; r_pend <= 1'b0; aw_pend <= 1'b0;
      w_pend  <= 1'b0; b_pend <= 1'b0;
    end else begin
      ar_pend <= ar_pend_nxt; r_pend <= r_pend_nxt; aw_pend <= aw_pend_nxt;
      w_pend  <= w_pend_nxt;  b_pend <= b_pend_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      is_wr   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      is_wr   <= is_wr_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    is_wr_nxt   = is_wr;
    err_nxt     = err_q;
    rdata_nxt   = rdata_q;
    we_dmem     = 1'b0;
    wstrb_dmem  = '0;
    addr_dmem   = '0;
    din_dmem    = '0;
    rvalid_lsu  = 1'b0;
    wready_lsu  = 1'b0;
    err_lsu     = 1'b0;
    data_lsu_o  = '0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
`ifdef LSU_AXI_TIMEOUT_EN
    ar_pend_nxt = ar_pend;
    r_pend_nxt  = r_pend;
    aw_pend_nxt = aw_pend;
    w_pend_nxt  = w_pend;
    b_pend_nxt  = b_pend;
`endif
    // Outputs are forced quiet while reset is held.
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (dmem_hit) begin
            addr_dmem  = dmem_word;
            din_dmem   = data_lsu_i;
            we_dmem    = wvalid_lsu;
            wstrb_dmem = wvalid_lsu ? strb_lsu : 4'h0;
            data_lsu_o = dout_dmem;
            wready_lsu = wvalid_lsu;
            rvalid_lsu = rready_lsu && !wvalid_lsu;
          end else if (periph_hit) begin
            err_nxt   = 1'b0;
            rdata_nxt = '0;
            if (wvalid_lsu) begin
              state_nxt   = ST_WR_AW;
              is_wr_nxt   = 1'b1;
              aw_done_nxt = 1'b0;
              w_done_nxt  = 1'b0;
            end else if (rready_lsu) begin
              state_nxt = ST_RD_A;
              is_wr_nxt = 1'b0;
            end
          end else if (rready_lsu || wvalid_lsu) begin
            err_lsu    = 1'b1;
            data_lsu_o = DEAD_BEEF;
            wready_lsu = wvalid_lsu;
            rvalid_lsu = rready_lsu && !wvalid_lsu;
          end
        end
        ST_RD_A: begin
          m_arvalid = 1'b1;
          if (m_arready) state_nxt = ST_RD_D;
        end
        ST_RD_D: begin
          m_rready = 1'b1;
          if (m_rvalid) begin
            rdata_nxt = m_rdata;
            err_nxt   = (m_rresp != AXI_RESP_OKAY);
            state_nxt = ST_RESP;
          end
        end
        ST_WR_AW: begin
          // AW and W are independent; each valid drops after its own beat.
          m_awvalid   = !aw_done;
          m_wvalid    = !w_done;
          aw_done_nxt = aw_done || m_awready;
          w_done_nxt  = w_done || m_wready;
          if (aw_done_nxt && w_done_nxt) state_nxt = ST_WR_B;
        end
        ST_WR_B: begin
          m_bready = 1'b1;
          if (m_bvalid) begin
            err_nxt   = (m_bresp != AXI_RESP_OKAY);
            state_nxt = ST_RESP;
          end
        end
        ST_RESP: begin
          rvalid_lsu = !is_wr;
          wready_lsu = is_wr;
          err_lsu    = err_q;
          data_lsu_o = rdata_q;
          state_nxt  = ST_IDLE;
`ifdef LSU_AXI_TIMEOUT_EN
          if (ar_pend || r_pend || aw_pend || w_pend || b_pend) state_nxt = ST_DRAIN;
        end
        ST_DRAIN: begin
          // Finish whatever the slave still owes before taking new requests.
          m_arvalid = ar_pend;
          m_awvalid = aw_pend;
          m_wvalid  = w_pend;
          m_rready  = 1'b1;
          m_bready  = 1'b1;
          if (m_arready) ar_pend_nxt = 1'b0;
          if (m_awready) aw_pend_nxt = 1'b0;
          if (m_wready)  w_pend_nxt  = 1'b0;
          if (m_rvalid)  r_pend_nxt  = 1'b0;
          if (m_bvalid)  b_pend_nxt  = 1'b0;
          if (!(ar_pend_nxt || r_pend_nxt || aw_pend_nxt || w_pend_nxt || b_pend_nxt))
            state_nxt = ST_IDLE;
`endif
        end
        default: state_nxt = ST_IDLE;
      endcase
`ifdef LSU_AXI_TIMEOUT_EN
      // A normal completion in the same cycle takes priority over timeout.
      if (waiting && state_nxt != ST_RESP && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state_nxt   = ST_RESP;
        err_nxt     = 1'b1;
        rdata_nxt   = is_wr ? 32'h0 : DEAD_BEEF;
        ar_pend_nxt = (state == ST_RD_A) && !m_arready;
        r_pend_nxt  = !is_wr;
        aw_pend_nxt = (state == ST_WR_AW) && !aw_done_nxt;
        w_pend_nxt  = (state == ST_WR_AW) && !w_done_nxt;
        b_pend_nxt  = is_wr;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_interconnect_axil.sv
// tb_lsu_interconnect_axil: directed bench for lsu_interconnect_axil.
// Single-cycle DMEM/unmapped accesses run from a vector table; AXI reads,
// writes, reset-in-flight and (with LSU_AXI_TIMEOUT_EN) the timeout path
// run as hand-written sequences against a scripted slave.
module tb_lsu_interconnect_axil;
  import lsu_ic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_dmem;
  logic [3:0]  wstrb_dmem;
  logic [9:0]  addr_dmem;
  logic [31:0] din_dmem, dout_dmem;
  logic        rready_lsu, rvalid_lsu, wvalid_lsu, wready_lsu, err_lsu;
  logic [3:0]  strb_lsu;
  logic [31:0] addr_lsu, data_lsu_i, data_lsu_o;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset / DMEM model ----------------
  always #5 clk = ~clk;

  logic        mem_clr;
  logic [31:0] mem [1024];
  assign dout_dmem = mem[addr_dmem];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (we_dmem) begin
      for (int b = 0; b < 4; b++)
        if (wstrb_dmem[b]) mem[addr_dmem][8*b +: 8] <= din_dmem[8*b +: 8];
    end
  end

  lsu_interconnect_axil dut (
    .clk(clk), .rst(rst),
    .we_dmem(we_dmem), .wstrb_dmem(wstrb_dmem), .addr_dmem(addr_dmem),
    .din_dmem(din_dmem), .dout_dmem(dout_dmem),
    .rready_lsu(rready_lsu), .rvalid_lsu(rvalid_lsu),
    .wvalid_lsu(wvalid_lsu), .wready_lsu(wready_lsu), .err_lsu(err_lsu),
    .strb_lsu(strb_lsu), .addr_lsu(addr_lsu),
    .data_lsu_i(data_lsu_i), .data_lsu_o(data_lsu_o),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic axi_quiet();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = 32'h0;
  endtask

  task automatic cpu_idle();
    rready_lsu = 1'b0; wvalid_lsu = 1'b0; strb_lsu = 4'h0;
    addr_lsu = 32'h0; data_lsu_i = 32'h0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wv, rv;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic        e_we;
    logic [9:0]  e_adm;
    logic        e_wr, e_rv, e_err;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  // ---------------- AXI read sequence ----------------
  task automatic axi_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                          input logic [31:0] rd, input logic [1:0] rr, input logic e_err);
    int ar_w, r_w, ar_cyc, pulses, pulse_cyc, stray;
    logic r_done;
    ar_w = 0; r_w = 0; ar_cyc = 0; pulses = 0; pulse_cyc = -1; stray = 0; r_done = 1'b0;
    @(negedge clk);
    addr_lsu = a; rready_lsu = 1'b1; wvalid_lsu = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      axi_quiet();
      if (m_arvalid) begin
        ar_cyc++;
        check("rd_araddr", m_araddr, a);
        check("rd_arprot", {29'h0, m_arprot}, 32'h0);
        if (ar_w == ar_dly) m_arready = 1'b1;
        ar_w++;
      end
      if (m_rready && !r_done) begin
        if (r_w == r_dly) begin
          m_rvalid = 1'b1; m_rdata = rd; m_rresp = rr; r_done = 1'b1;
        end
        r_w++;
      end
      #1;
      if (wready_lsu || m_awvalid || m_wvalid) stray++;
      if (rvalid_lsu) begin
        pulses++;
        pulse_cyc = c;
        check("rd_data", data_lsu_o, rd);
        check("rd_err", {31'h0, err_lsu}, {31'h0, e_err});
        rready_lsu = 1'b0;
      end
    end
    check("rd_pulses", pulses, 1);
    check("rd_latency", pulse_cyc, ar_dly + r_dly + 3);
    check("rd_ar_cycles", ar_cyc, ar_dly + 1);
    check("rd_stray", stray, 0);
    check("rd_end_quiet", {30'h0, m_arvalid, m_rready}, 32'h0);
    cpu_idle();
  endtask

  // ---------------- AXI write sequence ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [1:0] br, input logic e_err);
    int aw_w, w_w, b_w, aw_cyc, w_cyc, pulses, pulse_cyc, stray, mx;
    logic b_done;
    aw_w = 0; w_w = 0; b_w = 0; aw_cyc = 0; w_cyc = 0; pulses = 0;
    pulse_cyc = -1; stray = 0; b_done = 1'b0;
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    @(negedge clk);
    addr_lsu = a; data_lsu_i = d; strb_lsu = s; wvalid_lsu = 1'b1; rready_lsu = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      axi_quiet();
      if (m_awvalid) begin
        aw_cyc++;
        check("wr_awaddr", m_awaddr, a);
        if (aw_w == aw_dly) m_awready = 1'b1;
        aw_w++;
      end
      if (m_wvalid) begin
        w_cyc++;
        check("wr_wdata", m_wdata, d);
        check("wr_wstrb", {28'h0, m_wstrb}, {28'h0, s});
        if (w_w == w_dly) m_wready = 1'b1;
        w_w++;
      end
      if (m_bready && !b_done) begin
        if (b_w == b_dly) begin
          m_bvalid = 1'b1; m_bresp = br; b_done = 1'b1;
        end
        b_w++;
      end
      #1;
      if (rvalid_lsu || m_arvalid || we_dmem) stray++;
      if (wready_lsu) begin
        pulses++;
        pulse_cyc = c;
        check("wr_err", {31'h0, err_lsu}, {31'h0, e_err});
        wvalid_lsu = 1'b0;
      end
    end
    check("wr_pulses", pulses, 1);
    check("wr_latency", pulse_cyc, mx + b_dly + 3);
    check("wr_aw_cycles", aw_cyc, aw_dly + 1);
    check("wr_w_cycles", w_cyc, w_dly + 1);
    check("wr_stray", stray, 0);
    check("wr_end_quiet", {29'h0, m_awvalid, m_wvalid, m_bready}, 32'h0);
    cpu_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    //          wv    rv    addr            wdata          strb  we    adm    wr    rv    err   data
    vecs[0]  = '{1'b1, 1'b0, 32'h1000_0010, 32'hA5A5_1234, 4'hF, 1'b1, 10'd4,    1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h1000_0010, 32'h0,         4'h0, 1'b0, 10'd4,    1'b0, 1'b1, 1'b0, 32'hA5A5_1234};
    vecs[2]  = '{1'b1, 1'b0, 32'h1000_0014, 32'h1122_3344, 4'hF, 1'b1, 10'd5,    1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h1000_0014, 32'hAABB_CCDD, 4'h5, 1'b1, 10'd5,    1'b1, 1'b0, 1'b0, 32'h1122_3344};
    vecs[4]  = '{1'b0, 1'b1, 32'h1000_0014, 32'h0,         4'h0, 1'b0, 10'd5,    1'b0, 1'b1, 1'b0, 32'h11BB_33DD};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,         4'h0, 1'b0, 10'd0,    1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 1'b0, 32'h3000_0000, 32'h1,         4'hF, 1'b0, 10'd0,    1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 1'b1, 32'h1000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b1, 10'd1023, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h1000_0FFC, 32'h0,         4'h0, 1'b0, 10'd1023, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 1'b1, 32'h1000_1000, 32'h0,         4'h0, 1'b0, 10'd0,    1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 1'b1, 32'h0FFF_FFFC, 32'h0,         4'h0, 1'b0, 10'd0,    1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 1'b1, 32'h2001_0000, 32'h0,         4'h0, 1'b0, 10'd0,    1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 1'b0, 32'h1000_0010, 32'h0,         4'h0, 1'b0, 10'd4,    1'b0, 1'b0, 1'b0, 32'hA5A5_1234};

    // Reset with a live request: completions must stay quiet.
    rst = 1'b1; mem_clr = 1'b1;
    axi_quiet(); cpu_idle();
    rready_lsu = 1'b1; addr_lsu = 32'h0000_0004;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", {31'h0, rvalid_lsu}, 32'h0);
    check("rst_err", {31'h0, err_lsu}, 32'h0);
    check("rst_data", data_lsu_o, 32'h0);
    check("rst_axi", {27'h0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 32'h0);
    cpu_idle();
    rst = 1'b0; mem_clr = 1'b0;

    // Single-cycle DMEM / unmapped accesses.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wvalid_lsu = vecs[i].wv; rready_lsu = vecs[i].rv; addr_lsu = vecs[i].addr;
      data_lsu_i = vecs[i].wdata; strb_lsu = vecs[i].strb;
      #1;
      check($sformatf("v%0d_we", i), {31'h0, we_dmem}, {31'h0, vecs[i].e_we});
      check($sformatf("v%0d_adm", i), {22'h0, addr_dmem}, {22'h0, vecs[i].e_adm});
      check($sformatf("v%0d_wready", i), {31'h0, wready_lsu}, {31'h0, vecs[i].e_wr});
      check($sformatf("v%0d_rvalid", i), {31'h0, rvalid_lsu}, {31'h0, vecs[i].e_rv});
      check($sformatf("v%0d_err", i), {31'h0, err_lsu}, {31'h0, vecs[i].e_err});
      check($sformatf("v%0d_data", i), data_lsu_o, vecs[i].e_data);
      check($sformatf("v%0d_axi", i), {29'h0, m_arvalid, m_awvalid, m_wvalid}, 32'h0);
    end
    @(negedge clk);
    cpu_idle();

    // AXI sequences.
    axi_read(32'h2000_0008, 2, 0, 32'h1234_5678, AXI_RESP_OKAY, 1'b0);
    axi_read(32'h2000_FFFC, 0, 2, 32'hFEED_0001, AXI_RESP_DECERR, 1'b1);
    axi_write(32'h2000_000C, 32'h0BAD_F00D, 4'hF, 0, 3, 0, AXI_RESP_SLVERR, 1'b1);
    axi_write(32'h2000_0004, 32'h5555_AAAA, 4'h3, 0, 0, 1, AXI_RESP_OKAY, 1'b0);
    axi_write(32'h2000_0000, 32'h0000_0077, 4'h1, 2, 0, 0, AXI_RESP_OKAY, 1'b0);

    // Reset while waiting in RD_D.
    @(negedge clk);
    addr_lsu = 32'h2000_0000; rready_lsu = 1'b1;
    @(negedge clk);
    #1;
    check("rstmid_arvalid", {31'h0, m_arvalid}, 32'h1);
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    #1;
    check("rstmid_in_rd_d", {31'h0, m_rready}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rready_lsu = 1'b0;
    #1;
    check("rstmid_axi", {27'h0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 32'h0);
    check("rstmid_rvalid", {31'h0, rvalid_lsu}, 32'h0);
    @(negedge clk);
    addr_lsu = 32'h1000_0010; rready_lsu = 1'b1;
    #1;
    check("rstmid_dmem_rvalid", {31'h0, rvalid_lsu}, 32'h1);
    check("rstmid_dmem_data", data_lsu_o, 32'hA5A5_1234);
    @(negedge clk);
    cpu_idle();

`ifdef LSU_AXI_TIMEOUT_EN
    // Silent slave: timeout completion, then drain a late AR/R pair.
    begin : to_test
      int pc;
      pc = -1;
      @(negedge clk);
      addr_lsu = 32'h2000_0010; rready_lsu = 1'b1;
      for (int c = 0; c < 300; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        if (rvalid_lsu && pc < 0) begin
          pc = c;
          check("to_err", {31'h0, err_lsu}, 32'h1);
          check("to_data", data_lsu_o, 32'hDEAD_BEEF);
          rready_lsu = 1'b0;
        end
      end
      check("to_latency", pc, 256);
      check("to_drain_arvalid", {31'h0, m_arvalid}, 32'h1);
      @(negedge clk); m_arready = 1'b1;
      @(negedge clk); m_arready = 1'b0;
      #1;
      check("to_drain_rready", {31'h0, m_rready}, 32'h1);
      m_rvalid = 1'b1; m_rdata = 32'h0;
      @(negedge clk); m_rvalid = 1'b0;
      addr_lsu = 32'h1000_0010; rready_lsu = 1'b1;
      #1;
      check("to_after_arvalid", {31'h0, m_arvalid}, 32'h0);
      check("to_after_rvalid", {31'h0, rvalid_lsu}, 32'h1);
      check("to_after_data", data_lsu_o, 32'hA5A5_1234);
      @(negedge clk);
      cpu_idle();
    end
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
